// File: rtl/param_fifo.sv
// param_fifo: synchronous FIFO with a configurable width and depth, registered
// status flags, overflow/underflow pulses and a choice of registered or
// first-word-fall-through read data.
//
// Parameters:
//   WIDTH    data word width (>= 1)
//   DEPTH    number of entries (power of two, >= 2)
//   AF_LEVEL almost_full when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL almost_empty when count <= AE_LEVEL (0..DEPTH-1)
//   FWFT     0 = rdata loaded on the edge that accepts a read
//            1 = head word presented on rdata while not empty
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   wdata/wr_en  write data / write request
//   rdata/rd_en  read data / read request
//   full_flag    count == DEPTH
//   empty_flag   count == 0
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
//   count        occupancy, 0..DEPTH
//   overflow     one-cycle pulse after a rejected write
//   underflow    one-cycle pulse after a rejected read
module param_fifo #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       wr_en,
  output logic                       full_flag,
  output logic [WIDTH-1:0]           rdata,
  input  logic                       rd_en,
  output logic                       empty_flag,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_afull;
  logic             r_aempty;
  logic             r_ovf;
  logic             r_unf;
  logic [WIDTH-1:0] r_rdata;

  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [CW-1:0]    w_count_nxt;

  // A write into a full FIFO is still accepted when a read frees a slot on
  // the same edge.
  assign w_rd_acc = rd_en && !r_empty;
  assign w_wr_acc = wr_en && (!r_full || w_rd_acc);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage is not reset; stale contents are unreachable once the pointers
  // and count are cleared.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= wdata;
  end

  // Status flags are computed from the next count so they change on the
  // same edge as count itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
      if (w_rd_acc) begin
        r_rptr  <= r_rptr + AW'(1);
        r_rdata <= r_mem[r_rptr];
      end
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == FULL_C);
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= AF_C);
      r_aempty <= (w_count_nxt <= AE_C);
      r_ovf    <= wr_en && !w_wr_acc;
      r_unf    <= rd_en && r_empty;
    end
  end

  // In fall-through mode the head word is shown directly while data is
  // present; once empty, the last popped word (or 0 after reset) is held.
  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = r_empty ? r_rdata : r_mem[r_rptr];
    end else begin : g_std
      assign rdata = r_rdata;
    end
  endgenerate

  assign full_flag    = r_full;
  assign empty_flag   = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_param_fifo.sv
// Testbench for param_fifo: two instances (standard and fall-through read)
// driven by the same stimulus and checked against a queue-based model.
module tb_param_fifo;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AFL   = 6;
  localparam int unsigned AEL   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;

  logic             full0, empty0, af0, ae0, ovf0, unf0;
  logic [WIDTH-1:0] rdata0;
  logic [3:0]       count0;
  logic             full1, empty1, af1, ae1, ovf1, unf1;
  logic [WIDTH-1:0] rdata1;
  logic [3:0]       count1;

  param_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wdata(wdata), .wr_en(wr_en), .full_flag(full0),
    .rdata(rdata0), .rd_en(rd_en), .empty_flag(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(unf0)
  );

  param_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wdata(wdata), .wr_en(wr_en), .full_flag(full1),
    .rdata(rdata1), .rd_en(rd_en), .empty_flag(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(unf1)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_last;
  logic             m_ovf, m_unf;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int unsigned n;
    n = q.size();
    chk({tag, ".count0"}, 64'(count0), 64'(n));
    chk({tag, ".count1"}, 64'(count1), 64'(n));
    chk({tag, ".full0"},  64'(full0),  64'(n == DEPTH));
    chk({tag, ".full1"},  64'(full1),  64'(n == DEPTH));
    chk({tag, ".empty0"}, 64'(empty0), 64'(n == 0));
    chk({tag, ".empty1"}, 64'(empty1), 64'(n == 0));
    chk({tag, ".af0"},    64'(af0),    64'(n >= AFL));
    chk({tag, ".af1"},    64'(af1),    64'(n >= AFL));
    chk({tag, ".ae0"},    64'(ae0),    64'(n <= AEL));
    chk({tag, ".ae1"},    64'(ae1),    64'(n <= AEL));
    chk({tag, ".ovf0"},   64'(ovf0),   64'(m_ovf));
    chk({tag, ".ovf1"},   64'(ovf1),   64'(m_ovf));
    chk({tag, ".unf0"},   64'(unf0),   64'(m_unf));
    chk({tag, ".unf1"},   64'(unf1),   64'(m_unf));
    chk({tag, ".rdata0"}, 64'(rdata0), 64'(m_last));
    if (n > 0) chk({tag, ".rdata1"}, 64'(rdata1), 64'(q[0]));
  endtask

  // One clock cycle: drive inputs, advance the model, sample after the edge.
  task automatic cyc(input logic wr, input logic rd, input logic [WIDTH-1:0] wd, input string tag);
    bit rd_acc, wr_acc;
    wr_en = wr;
    rd_en = rd;
    wdata = wd;
    rd_acc = rd && (q.size() > 0);
    wr_acc = wr && ((q.size() < DEPTH) || rd_acc);
    m_ovf = wr && !wr_acc;
    m_unf = rd && (q.size() == 0);
    @(posedge clk);
    if (rd_acc) m_last = q.pop_front();
    if (wr_acc) q.push_back(wd);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_last = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] v;
    model_reset();

    // Reset state, with the clock running
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    #3 rst = 1'b1;
    @(posedge clk); #1;
    check_all("post_reset");

    // Fill then drain with alternating pattern
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, (i % 2 == 0) ? 32'hD4F40099 : 32'h281B86C4, "fill");
    chk("fill.full_after_8", 64'(full0), 64'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, '0, "drain");
      chk("drain.order", 64'(rdata0), (i % 2 == 0) ? 64'hD4F40099 : 64'h281B86C4);
    end
    chk("drain.empty_after_8", 64'(empty0), 64'd1);

    // Underflow: rdata held, count stays 0
    cyc(1'b0, 1'b1, '0, "underflow");
    chk("underflow.pulse", 64'(unf0), 64'd1);
    chk("underflow.rdata_held", 64'(rdata0), 64'h281B86C4);
    cyc(1'b0, 1'b0, '0, "underflow_end");

    // Overflow: write while full, then drain and look for the rejected word
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, $urandom & 32'h7FFFFFFF, "ovf_fill");
    cyc(1'b1, 1'b0, 32'hBABABABA, "overflow");
    chk("overflow.pulse", 64'(ovf0), 64'd1);
    chk("overflow.count", 64'(count0), 64'd8);
    cyc(1'b0, 1'b0, '0, "overflow_end");
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, '0, "ovf_drain");
      n_cmp++;
      assert (rdata0 !== 32'hBABABABA) else begin
        n_err++;
        $error("FAIL ovf_drain.discard: observed %h expected not BABABABA", rdata0);
      end
    end

    // Simultaneous read and write when full, then at count 3
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 32'h100 + i, "rw_fill");
    cyc(1'b1, 1'b1, 32'hCAFE0001, "rw_full");
    chk("rw_full.oldest", 64'(rdata0), 64'h100);
    chk("rw_full.count", 64'(count0), 64'd8);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, '0, "rw_drain5");
    cyc(1'b1, 1'b1, 32'hCAFE0002, "rw_three");
    chk("rw_three.count", 64'(count0), 64'd3);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, '0, "rw_drain3");

    // Write and read together while empty: write taken, read rejected
    cyc(1'b1, 1'b1, 32'h5A5A0000, "rw_empty");
    chk("rw_empty.unf", 64'(unf0), 64'd1);
    chk("rw_empty.count", 64'(count0), 64'd1);
    cyc(1'b0, 1'b1, '0, "rw_empty_pop");

    // Wrap-around: 20 write/read pairs carrying 0..19
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 32'(i), "wrap_wr");
      cyc(1'b0, 1'b1, '0, "wrap_rd");
      chk("wrap.value", 64'(rdata0), 64'(i));
    end

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      v = $urandom;
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), v, "random");
    end
    while (q.size() > 0) cyc(1'b0, 1'b1, '0, "final_drain");

    // Reset mid-operation
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'hFEFEFEFE, "pre_rst");
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.count", 64'(count0), 64'd0);
    chk("async_rst.empty", 64'(empty1), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 1'b1, '0, "rst_read_empty");
    chk("rst_read_empty.rdata0", 64'(rdata0), 64'd0);
    chk("rst_read_empty.rdata1", 64'(rdata1), 64'd0);
    cyc(1'b1, 1'b0, 32'hFEFEFEFE, "fwft_first");
    chk("fwft_first.rdata1", 64'(rdata1), 64'hFEFEFEFE);
    chk("fwft_first.rdata0", 64'(rdata0), 64'd0);
    cyc(1'b0, 1'b1, '0, "fwft_pop");
    chk("fwft_pop.rdata0", 64'(rdata0), 64'hFEFEFEFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
